// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS boot-time program loader.
package mips_loader_pkg;

   typedef enum logic [2:0] {
      StHdr,
      StLoad,
      StCsum,
      StDone,
      StErr
   } state_e;

   localparam int unsigned HDR_BYTES          = 4;
   localparam int unsigned CSUM_BYTES         = 4;
   localparam int unsigned DEFAULT_IMEM_DEPTH = 1024;

endpackage

// File: rtl/mips_program_loader_byte_word_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words; word_valid pulses
// combinationally alongside the 4th byte so the caller can register the write.
module byte_word_packer
   import mips_loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LastPos = 2'(HDR_BYTES - 1);

   logic [23:0] shift_q;
   logic [1:0]  pos_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         pos_q   <= '0;
      end else if (clear) begin
         shift_q <= '0;
         pos_q   <= '0;
      end else if (byte_valid) begin
         shift_q <= {shift_q[15:0], byte_data};
         pos_q   <= pos_q + 2'd1;
      end
   end

   assign word       = {shift_q, byte_data};
   assign word_valid = byte_valid && (pos_q == LastPos);

endmodule

// File: rtl/mips_program_loader.sv
// Byte-stream program loader for the MIPS instruction memory.
// Define MIPS_LOADER_CHECKSUM_EN to require a trailing 32-bit word-sum checksum.
module mips_program_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
   parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   state_e            state_q, state_d;
   state_e            after_words;
   logic [ADDR_W:0]   count_q, count_d, count_inc;
   logic [ADDR_W:0]   num_q, num_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              accept, word_valid, pack_clear;
   logic [31:0]       word;

`ifdef MIPS_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
   localparam logic [1:0] CsumLast = 2'(CSUM_BYTES - 1);
   assign after_words = StCsum;
`else
   assign after_words = StDone;
`endif

   // Reset gates ready directly since the state register already sits in HDR.
   assign in_ready   = !reset && (state_q inside {StHdr, StLoad, StCsum});
   assign accept     = in_valid && in_ready;
   assign pack_clear = (state_q == StDone) || (state_q == StErr);
   assign count_inc  = count_q + (ADDR_W + 1)'(1);

   byte_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (pack_clear),
      .byte_valid (accept),
      .byte_data  (in_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      count_d = count_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         StHdr: begin
            if (word_valid) begin
               num_d = word[ADDR_W:0];
               if (word == '0) begin
                  state_d = after_words;
               end else if (word > IMEM_DEPTH) begin
                  state_d = StErr;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (word_valid) begin
               we_d    = 1'b1;
               addr_d  = count_q[ADDR_W-1:0];
               wdata_d = word;
               count_d = count_inc;
`ifdef MIPS_LOADER_CHECKSUM_EN
               sum_d   = sum_q + word;
`endif
               if (count_inc == num_q) begin
                  state_d = after_words;
               end
            end
         end
`ifdef MIPS_LOADER_CHECKSUM_EN
         StCsum: begin
            if (word_valid) begin
               state_d = (word == sum_q) ? StDone : StErr;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StHdr;
         num_q   <= '0;
         count_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

`ifdef MIPS_LOADER_CHECKSUM_EN
   logic unused_csum_last;
   assign unused_csum_last = ^CsumLast;
`endif

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = count_q;
   assign load_err     = (state_q == StErr);
   // Held off while the final strobe is still on the bus.
   assign cpu_run      = (state_q == StDone) && !we_q;

endmodule
